// File: rtl/enc_priority_rr.sv
// Registered N-way request encoder with sticky pending bits, fixed or round-robin selection,
// a valid/ready output stage and a saturating counter of merged (duplicate) requests.
module enc_priority_rr #(
    parameter int N    = 8,
    parameter int IDXW = 3,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_in,
    input  logic            mode,
    output logic [IDXW-1:0] out_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    pend,
    output logic [CNTW-1:0] coalesce_cnt
);

    logic [N-1:0]    pend_r;
    logic [IDXW-1:0] out_idx_r;
    logic            out_valid_r;
    logic [IDXW-1:0] ptr_r;
    logic [CNTW-1:0] cnt_r;

    logic [IDXW-1:0] sel_fix_s;
    logic [IDXW-1:0] sel_hi_s;
    logic [IDXW-1:0] sel_lo_s;
    logic            found_hi_s;
    logic [IDXW-1:0] sel_s;
    logic [IDXW-1:0] ptr_nxt_s;
    logic            load_s;
    logic [N-1:0]    clr_s;
    logic            coal_s;

    // Selection, load decision, clear mask and coalesce detection from the current pend register
    always_comb begin
        sel_fix_s  = {IDXW{1'b0}};
        sel_hi_s   = {IDXW{1'b0}};
        sel_lo_s   = {IDXW{1'b0}};
        found_hi_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend_r[i]) begin
                sel_fix_s = IDXW'(i);
            end else begin
                sel_fix_s = sel_fix_s;
            end
        end
        // Round-robin: lowest set index at or above ptr, otherwise wrap to lowest set index overall
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_r[i] && (i >= int'(ptr_r))) begin
                sel_hi_s   = IDXW'(i);
                found_hi_s = 1'b1;
            end else begin
                sel_hi_s   = sel_hi_s;
            end
            if (pend_r[i]) begin
                sel_lo_s = IDXW'(i);
            end else begin
                sel_lo_s = sel_lo_s;
            end
        end

        if (mode) begin
            sel_s = found_hi_s ? sel_hi_s : sel_lo_s;
        end else begin
            sel_s = sel_fix_s;
        end

        if (sel_s == IDXW'(N - 1)) begin
            ptr_nxt_s = {IDXW{1'b0}};
        end else begin
            ptr_nxt_s = sel_s + IDXW'(1);
        end

        load_s = (pend_r != {N{1'b0}}) && (!out_valid_r || out_ready);
        if (load_s) begin
            clr_s = {{(N-1){1'b0}}, 1'b1} << sel_s;
        end else begin
            clr_s = {N{1'b0}};
        end
        coal_s = |(req_in & pend_r & ~clr_s);
    end

    // State update: pending vector, output stage, round-robin pointer and coalesce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r      <= {N{1'b0}};
            out_idx_r   <= {IDXW{1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {IDXW{1'b0}};
            cnt_r       <= {CNTW{1'b0}};
        end else begin
            pend_r <= (pend_r & ~clr_s) | req_in;

            if (load_s) begin
                out_idx_r   <= sel_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            if (load_s && mode) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end

            if (coal_s && (cnt_r != {CNTW{1'b1}})) begin
                cnt_r <= cnt_r + CNTW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign out_idx      = out_idx_r;
    assign out_valid    = out_valid_r;
    assign pend         = pend_r;
    assign coalesce_cnt = cnt_r;

endmodule

// File: doc/enc_priority_rr.md
Name: enc_priority_rr

Overview:
Parametrised, registered successor to the team's 4:1 priority encoder. It captures a sticky N-bit request vector, selects one pending request per cycle using fixed highest-index priority or round-robin, and presents the encoded index on a valid/ready output stage. It sits between request sources (interrupt lines, channel flags) and a single consumer that services one index at a time.

Parameters:
N, 8, number of request inputs (2..64; need not be a power of two)
IDXW, 3, index width; must equal clog2(N)
CNTW, 8, width of the saturating coalesce counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
req_in  input  N  request pulses/levels; bit i requests service of index i
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
out_idx  output  IDXW  encoded index of the granted request
out_valid  output  1  out_idx holds a granted request
out_ready  input  1  consumer accepts out_idx when out_valid && out_ready
pend  output  N  current pending-request register
coalesce_cnt  output  CNTW  saturating count of cycles with a merged (duplicate) request

Behaviour:
- Reset (async, immediate): pend=0, out_valid=0, out_idx=0, round-robin pointer ptr=0, coalesce_cnt=0. Reset mid-operation discards all pending and in-flight grants. The first edge after deassertion behaves as normal operation.
- Load condition: load = (pend != 0) && (!out_valid || out_ready).
- Selection is combinational from pend only; req_in does not bypass pend.
- mode=0: sel = highest set index of pend.
- mode=1: sel = first set index found by searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- On load: out_idx <= sel, out_valid <= 1, and pend bit sel is cleared.
- If mode=1, ptr <= (sel==N-1) ? 0 : sel+1. The wrap is at N-1, not 2^IDXW-1.
- In mode=0, ptr holds its value. A mode change affects the next selection only; ptr is never reset by a mode change.
- Pend update each edge: pend <= (pend & ~clr) | req_in, where clr is the one-hot of sel when load, else 0.
- A set in the same cycle as a clear of the same bit wins: a held request is re-pended.
- Latency: req_in high at edge k sets pend at edge k. out_valid is high after edge k+1, provided the output stage is free.
- If !load && out_valid && out_ready: out_valid <= 0; out_idx holds its last value.
- Back-to-back: with out_ready held high and requests pending, one grant is issued per cycle with no bubble.
- Backpressure: while out_valid && !out_ready, out_idx and out_valid are stable, pend keeps accumulating, and ptr is frozen.
- Coalesce: a cycle counts if any bit has req_in[i] && pend[i] && !clr[i].
  - Each counted cycle increments coalesce_cnt by 1, regardless of how many bits coalesce.
  - The counter saturates at 2^CNTW-1 and never wraps.
- req_in of all zeros with pend=0 leaves all outputs unchanged except the out_valid drop on acceptance.

Test Plan:
- Fixed mode (N=8, mode=0, out_ready=1): pulse req_in=8'b0000_0011 for one cycle -> out_idx=1 then 0 on consecutive cycles; pend goes 0x03, 0x01, 0x00; out_valid deasserts the cycle after the second grant.
- Round-robin (mode=1, out_ready=1): hold req_in=8'b1000_0101 -> grant sequence 0,2,7,0,2,7; ptr wraps from 7 to 0; no idle cycle between grants.
- Backpressure: out_ready=0, pulse req 0x10 -> out_valid=1, out_idx=4 held stable for 5 cycles. Then pulse req 0x20 -> pend=0x20. Raise out_ready -> next cycle out_idx=5, then out_valid=0.
- Coalesce/saturation: out_ready=0, grant 6 occupying the output, then pulse req bit 3 on three separate cycles -> pend=0x08, coalesce_cnt=2. Force 300 coalesce cycles with CNTW=8 -> coalesce_cnt=255 and holding.
- Non-power-of-two (N=5, IDXW=3, mode=1): hold req_in=5'b10001 -> grants 0,4,0,4; out_idx never exceeds 4.
- Async reset: assert rst mid-stream (out_valid=1, pend=0x0C) between clock edges -> out_valid, pend, coalesce_cnt and out_idx are 0 immediately. After release with req 0x0C, mode=1 -> first grant is 2 (ptr reset to 0).
